spi_cmd_ctrl: RTL and testbench
===============================

# spi_cmd_ctrl

SYS_CLK-domain command controller for the SPI slave unit. It consumes each completed 16-bit MOSI word (`data_from_mosi`) and decodes a two-frame read/write protocol onto a 7-entry configuration register file plus one read-only status register. It drives `data_in_SPI` so that the correct response word is parallel-loaded into the MISO shifter at the next frame start.

## Interface
Parameters: none. Widths are fixed: 16-bit words, 8 addresses.

Ports:
- SYS_CLK  in  1  system clock; all logic is on its rising edge
- all_clear  in  1  reset; synchronous, active-high
- CS  in  1  SPI chip select, active-low; asynchronous to SYS_CLK and synchronised internally
- strob_LOAD  in  1  frame-start strobe from the SPI unit, synchronous to SYS_CLK; a rising edge marks frame start
- data_from_mosi  in  16  last completed MOSI word; stable from CS rise until the next CS rise
- data_in_SPI  out  16  word loaded into the MISO shifter at the next strob_LOAD rise
- cfg_out  out  112  registers 0..6; reg k occupies [16k+15:16k]
- wr_stb  out  1  one-cycle pulse on every register write
- wr_addr  out  3  address of the write; valid with wr_stb
- wr_data  out  16  data of the write; valid with wr_stb
- err_flag  out  1  high while err_cnt != 0

## Operation
- Command word fields:
  - [15:12] opcode: 4'hA = WRITE, 4'h5 = READ, 4'h0 = NOP; any other value is invalid.
  - [2:0] addr.
  - [11:3] ignored.
- Status word (address 7, read-only): {ovr, 3'b100, err_cnt[3:0], frame_cnt[7:0]}.
- States:
  - CMD: each frame is a command.
    - WRITE with addr 0..6: go to WDATA.
    - WRITE with addr 7: error (err_cnt+1), stay in CMD.
    - READ: data_in_SPI <= reg[addr] (status if addr 7), stay in CMD.
    - NOP: data_in_SPI <= status, stay in CMD.
    - Invalid opcode: err_cnt+1, data_in_SPI <= status, stay in CMD.
  - WDATA: the frame is data.
    - reg[addr] <= word; wr_stb = 1 for one cycle with wr_addr/wr_data.
    - data_in_SPI <= status; go to CMD.
    - The data word is never decoded as a command.
- Full duplex: the MISO response to a READ goes out during the frame that follows the READ. The MOSI word of that frame is decoded as a new command.
- frame_cnt: 8-bit, increments on every completed frame, wraps 255 -> 0.
- err_cnt: 4-bit, saturates at 15.
- ovr: sticky. Set when a strob_LOAD rising edge occurs while an update is pending, i.e. in the cs_rise cycle or the cycle after. Cleared only by all_clear.
- Status words report counter values that already include the current frame.
- Reset values (all_clear high at a SYS_CLK edge):
  - state CMD, all regs 0, cfg_out 0.
  - frame_cnt 0, err_cnt 0, ovr 0.
  - wr_stb 0, wr_addr 0, wr_data 0, err_flag 0.
  - data_in_SPI 16'h4000.
  - Synchroniser flops are set to 1 (CS idle high).
- Reset mid-frame: the partial write transaction is discarded and the FSM returns to CMD.

## Timing
- CS passes through a 2-flop synchroniser. cs_rise is a one-cycle pulse on a 0->1 transition at the synchroniser output, 3 SYS_CLK edges after the CS rise.
- Cycle T (cs_rise): data_from_mosi is sampled into a holding register and frame_cnt increments.
- Cycle T+1: decode; data_in_SPI, regs, err_cnt, state and wr_stb are all updated at the end of T+1. Effective at T+2.
- Total latency from CS rise to a valid data_in_SPI: at most 5 SYS_CLK.
- System requirement: CS high time of at least 6 SYS_CLK. A violation is flagged by ovr.
- data_in_SPI never changes outside cycle T+1 (or reset).
- strob_LOAD is used only for ovr detection (rising edge = previous-cycle 0, current 1).
- Simultaneous all_clear and cs_rise: reset wins and the frame is lost.

## Test plan
- Reset: pulse all_clear -> data_in_SPI = 16'h4000, cfg_out = 0, wr_stb = 0, err_flag = 0.
- Write then read:
  - Frames 16'hA003, 16'h1234 -> wr_stb pulse with wr_addr = 3, wr_data = 16'h1234; cfg_out[63:48] = 16'h1234.
  - Next frame 16'h5003 -> data_in_SPI = 16'h1234 at T+2.
- Errors:
  - Frame 16'h7000 -> err_cnt = 1, err_flag = 1, status low byte = frame_cnt.
  - WRITE to addr 7 (16'hA007) -> err_cnt = 2, state stays CMD; the next frame is decoded as a command.
- Counters:
  - 256 NOP frames from reset -> frame_cnt wraps to 0; status reads 16'h4000.
  - 17 invalid frames -> err_cnt holds at 4'hF.
- Overrun: assert strob_LOAD rising in the cycle after cs_rise -> ovr = 1, status bit 15 set, persisting until all_clear.
- Reset mid-transaction: send 16'hA002, assert all_clear, then frame 16'hBEEF -> no write (reg2 stays 0), BEEF treated as an invalid command, err_cnt = 1.

Source files
------------

// File: rtl/spi_cmd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_cmd_ctrl                                                 |
// | Description : SYS_CLK-domain command decoder for the SPI slave. Decodes    |
// |               two-frame WRITE / single-frame READ / NOP commands onto a    |
// |               7-entry config register file plus a read-only status word,   |
// |               and prepares the next MISO response word.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_cmd_ctrl (
    input  logic         SYS_CLK,
    input  logic         all_clear,
    input  logic         CS,
    input  logic         strob_LOAD,
    input  logic [15:0]  data_from_mosi,
    output logic [15:0]  data_in_SPI,
    output logic [111:0] cfg_out,
    output logic         wr_stb,
    output logic [2:0]   wr_addr,
    output logic [15:0]  wr_data,
    output logic         err_flag
);

    localparam logic [0:0]  ST_CMD       = 1'b0;
    localparam logic [0:0]  ST_WDATA     = 1'b1;
    localparam logic [3:0]  C_OP_WRITE   = 4'hA;
    localparam logic [3:0]  C_OP_READ    = 4'h5;
    localparam logic [3:0]  C_OP_NOP     = 4'h0;
    localparam logic [2:0]  C_STATUS_ADR = 3'd7;
    localparam logic [15:0] C_RESET_WORD = 16'h4000;

    // CS synchroniser and edge detect
    logic        r_cs_meta;
    logic        r_cs_sync;
    logic        r_cs_prev;
    logic        r_cs_rise;

    // Frame pipeline and FSM state
    logic        r_pend;
    logic [15:0] r_hold;
    logic        r_strob_prev;
    logic [0:0]  r_state;
    logic [2:0]  r_waddr;
    logic [7:0]  r_frame_cnt;
    logic [3:0]  r_err_cnt;
    logic        r_ovr;
    logic [15:0] r_regs [0:6];

    logic        w_strob_rise;
    logic        w_ovr_next;
    logic [3:0]  w_op;
    logic [2:0]  w_addr;
    logic        w_err_inc;
    logic [3:0]  w_err_next;
    logic [15:0] w_status;
    logic [15:0] w_rd_word;

    assign w_op         = r_hold[15:12];
    assign w_addr       = r_hold[2:0];
    assign w_strob_rise = strob_LOAD & ~r_strob_prev;
    // A frame start while a decoded update is still in flight means CS high time was too short
    assign w_ovr_next   = r_ovr | (w_strob_rise & (r_cs_rise | r_pend));
    assign w_err_next   = (w_err_inc && (r_err_cnt != 4'hF)) ? (r_err_cnt + 4'd1) : r_err_cnt;
    // Status reflects counters already updated for the frame being decoded
    assign w_status     = {w_ovr_next, 3'b100, w_err_next, r_frame_cnt};

    // Flag error-producing commands in the decode cycle
    always_comb begin
        w_err_inc = 1'b0;
        if (r_pend && (r_state == ST_CMD)) begin
            case (w_op)
                C_OP_WRITE: w_err_inc = (w_addr == C_STATUS_ADR);
                C_OP_READ:  w_err_inc = 1'b0;
                C_OP_NOP:   w_err_inc = 1'b0;
                default:    w_err_inc = 1'b1;
            endcase
        end
    end

    // Read mux: config register or the status word at address 7
    always_comb begin
        w_rd_word = w_status;
        for (int k = 0; k < 7; k++) begin
            if (w_addr == 3'(k)) begin
                w_rd_word = r_regs[k];
            end
        end
    end

    // Two-flop CS synchroniser with registered rising-edge pulse
    always_ff @(posedge SYS_CLK) begin
        if (all_clear) begin
            r_cs_meta <= 1'b1;
            r_cs_sync <= 1'b1;
            r_cs_prev <= 1'b1;
            r_cs_rise <= 1'b0;
        end else begin
            r_cs_meta <= CS;
            r_cs_sync <= r_cs_meta;
            r_cs_prev <= r_cs_sync;
            r_cs_rise <= r_cs_sync & ~r_cs_prev;
        end
    end

    // Capture at cs_rise, decode one cycle later and update all outputs together
    always_ff @(posedge SYS_CLK) begin
        if (all_clear) begin
            r_pend       <= 1'b0;
            r_hold       <= 16'h0000;
            r_strob_prev <= 1'b0;
            r_state      <= ST_CMD;
            r_waddr      <= 3'd0;
            r_frame_cnt  <= 8'd0;
            r_err_cnt    <= 4'd0;
            r_ovr        <= 1'b0;
            data_in_SPI  <= C_RESET_WORD;
            wr_stb       <= 1'b0;
            wr_addr      <= 3'd0;
            wr_data      <= 16'h0000;
            err_flag     <= 1'b0;
            for (int k = 0; k < 7; k++) begin
                r_regs[k] <= 16'h0000;
            end
        end else begin
            r_strob_prev <= strob_LOAD;
            r_ovr        <= w_ovr_next;
            r_pend       <= r_cs_rise;
            wr_stb       <= 1'b0;

            if (r_cs_rise) begin
                r_hold      <= data_from_mosi;
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end

            if (r_pend) begin
                r_err_cnt <= w_err_next;
                err_flag  <= (w_err_next != 4'd0);
                if (r_state == ST_WDATA) begin
                    // Data frame: never decoded as a command
                    for (int k = 0; k < 7; k++) begin
                        if (r_waddr == 3'(k)) begin
                            r_regs[k] <= r_hold;
                        end
                    end
                    wr_stb      <= 1'b1;
                    wr_addr     <= r_waddr;
                    wr_data     <= r_hold;
                    data_in_SPI <= w_status;
                    r_state     <= ST_CMD;
                end else begin
                    case (w_op)
                        C_OP_WRITE: begin
                            if (w_addr != C_STATUS_ADR) begin
                                r_waddr <= w_addr;
                                r_state <= ST_WDATA;
                            end
                        end
                        C_OP_READ: data_in_SPI <= w_rd_word;
                        C_OP_NOP:  data_in_SPI <= w_status;
                        default:   data_in_SPI <= w_status;
                    endcase
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_cfg
            assign cfg_out[16*gi +: 16] = r_regs[gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_spi_cmd_ctrl                                              |
// | Description : Scoreboard bench for spi_cmd_ctrl. Stimulus pushes expected  |
// |               frame responses and register writes; monitors pop them when  |
// |               the DUT presents a response or a write strobe.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_spi_cmd_ctrl;

    logic         SYS_CLK = 1'b0;
    logic         all_clear = 1'b0;
    logic         CS = 1'b1;
    logic         strob_LOAD = 1'b0;
    logic [15:0]  data_from_mosi = 16'h0000;
    logic [15:0]  data_in_SPI;
    logic [111:0] cfg_out;
    logic         wr_stb;
    logic [2:0]   wr_addr;
    logic [15:0]  wr_data;
    logic         err_flag;

    int checks   = 0;
    int failures = 0;

    spi_cmd_ctrl u_dut (
        .SYS_CLK        (SYS_CLK),
        .all_clear      (all_clear),
        .CS             (CS),
        .strob_LOAD     (strob_LOAD),
        .data_from_mosi (data_from_mosi),
        .data_in_SPI    (data_in_SPI),
        .cfg_out        (cfg_out),
        .wr_stb         (wr_stb),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .err_flag       (err_flag)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    typedef struct {
        logic [15:0]  resp;
        logic         eflag;
        logic [111:0] cfg;
    } exp_t;

    exp_t        exp_q [$];
    logic [18:0] wr_q  [$];

    // Reference model: protocol-level view of the controller
    logic [15:0] m_regs [7];
    bit          m_wdata;
    logic [2:0]  m_addr;
    logic [7:0]  m_frame;
    logic [3:0]  m_err;
    bit          m_ovr;
    logic [15:0] m_resp;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] m_status();
        return {m_ovr, 3'b100, m_err, m_frame};
    endfunction

    function automatic logic [111:0] m_cfg();
        logic [111:0] c;
        for (int k = 0; k < 7; k++) c[16*k +: 16] = m_regs[k];
        return c;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 7; k++) m_regs[k] = 16'h0000;
        m_wdata = 0;
        m_addr  = 3'd0;
        m_frame = 8'd0;
        m_err   = 4'd0;
        m_ovr   = 0;
        m_resp  = 16'h4000;
    endtask

    task automatic model_frame(input logic [15:0] w, input bit ovr_hit);
        exp_t e;
        if (ovr_hit) m_ovr = 1;
        m_frame = m_frame + 8'd1;
        if (m_wdata) begin
            m_regs[m_addr] = w;
            wr_q.push_back({m_addr, w});
            m_resp  = m_status();
            m_wdata = 0;
        end else begin
            case (w[15:12])
                4'hA: begin
                    if (w[2:0] != 3'd7) begin
                        m_wdata = 1;
                        m_addr  = w[2:0];
                    end else if (m_err != 4'hF) begin
                        m_err = m_err + 4'd1;
                    end
                end
                4'h5: m_resp = (w[2:0] == 3'd7) ? m_status() : m_regs[w[2:0]];
                4'h0: m_resp = m_status();
                default: begin
                    if (m_err != 4'hF) m_err = m_err + 4'd1;
                    m_resp = m_status();
                end
            endcase
        end
        e.resp  = m_resp;
        e.eflag = (m_err != 4'd0);
        e.cfg   = m_cfg();
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge SYS_CLK);
        all_clear = 1'b1;
        repeat (2) @(negedge SYS_CLK);
        all_clear = 1'b0;
        model_reset();
    endtask

    // One SPI frame: CS low with frame-start strobe, then CS high for 8 cycles
    task automatic send_frame(input logic [15:0] w, input bit ovr_hit);
        @(negedge SYS_CLK);
        CS = 1'b0;
        strob_LOAD = 1'b1;
        data_from_mosi = w;
        repeat (2) @(negedge SYS_CLK);
        strob_LOAD = 1'b0;
        repeat (2) @(negedge SYS_CLK);
        model_frame(w, ovr_hit);
        CS = 1'b1;
        if (ovr_hit) begin
            repeat (4) @(negedge SYS_CLK);
            strob_LOAD = 1'b1;
            @(negedge SYS_CLK);
            strob_LOAD = 1'b0;
            repeat (3) @(negedge SYS_CLK);
        end else begin
            repeat (8) @(negedge SYS_CLK);
        end
    endtask

    // Response monitor: the response is valid 6 cycles after each CS rise
    initial begin
        exp_t e;
        forever begin
            @(posedge CS);
            repeat (6) @(negedge SYS_CLK);
            if (exp_q.size() == 0) begin
                chk("resp_queue_empty", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("data_in_SPI", data_in_SPI, e.resp);
                chk("err_flag", err_flag, e.eflag);
                chk("cfg_out", cfg_out, e.cfg);
            end
        end
    end

    // Write monitor: every strobe must match the next expected write
    always @(posedge SYS_CLK) begin
        #1;
        if (wr_stb) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_wr_stb", {wr_addr, wr_data}, 0);
            end else begin
                chk("wr_addr_data", {wr_addr, wr_data}, wr_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  op;
        logic [15:0] w;

        do_reset();
        @(negedge SYS_CLK);
        chk("reset_data_in_SPI", data_in_SPI, 16'h4000);
        chk("reset_cfg_out", cfg_out, 0);
        chk("reset_wr_stb", wr_stb, 0);
        chk("reset_err_flag", err_flag, 0);

        // Write then read back
        send_frame(16'hA003, 0);
        send_frame(16'h1234, 0);
        send_frame(16'h5003, 0);
        // Error cases and command-after-error
        send_frame(16'h7000, 0);
        send_frame(16'hA007, 0);
        send_frame(16'h0000, 0);
        send_frame(16'h5007, 0);

        // Frame counter wrap
        do_reset();
        for (int i = 0; i < 256; i++) send_frame(16'h0000, 0);
        // Error counter saturation
        for (int i = 0; i < 17; i++) send_frame(16'hF000, 0);
        send_frame(16'h5007, 0);

        // Overrun, then randomized traffic with ovr sticky
        do_reset();
        send_frame(16'h0000, 1);
        send_frame(16'h0000, 0);
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 3))
                0: op = 4'hA;
                1: op = 4'h5;
                2: op = 4'h0;
                default: op = 4'($urandom);
            endcase
            w = {op, 9'($urandom), 3'($urandom_range(0, 7))};
            if ($urandom_range(0, 4) == 0) w = 16'($urandom);
            send_frame(w, 0);
        end
        send_frame(16'h0000, 0);

        // Reset in the middle of a write transaction
        do_reset();
        send_frame(16'hA002, 0);
        do_reset();
        send_frame(16'hBEEF, 0);
        send_frame(16'h5002, 0);
        send_frame(16'h5007, 0);

        repeat (10) @(negedge SYS_CLK);
        chk("resp_queue_drained", exp_q.size(), 0);
        chk("wr_queue_drained", wr_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
